fta_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single external FTA 128-bit command bus between NPORTS bus masters inside one MPU: the icache controller, the CPU data port, a second data port and the table walker. Each cycle it grants at most one requesting master and registers that master's command onto the external bus. It routes every external response back to its originating master by `tid.channel`. It also limits outstanding reads per master and stalls all grants while the downstream bus signals retry.

---
 rtl/fta_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_fta_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fta_rr_arbiter.sv
// Round-robin arbiter sharing one FTA 128-bit command bus between NPORTS masters,
// with per-master outstanding-read limits and channel-based response routing.

package fta_arb_pkg;
    typedef struct packed {
        logic [3:0]   core;
        logic [3:0]   channel;
        logic [7:0]   tranid;
    } fta_tranid_t;

    typedef struct packed {
        logic         cyc;
        logic         we;
        logic [15:0]  sel;
        fta_tranid_t  tid;
        logic [31:0]  padr;
        logic [127:0] data1;
    } fta_cmd_request128_t;

    typedef struct packed {
        fta_tranid_t  tid;
        logic         ack;
        logic         rty;
        logic         err;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;
endpackage

module fta_rr_arbiter
    import fta_arb_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int CHAN_BASE = 0,
    parameter int MAX_OUT   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  fta_cmd_request128_t  [NPORTS-1:0]    req_i,
    output fta_cmd_response128_t [NPORTS-1:0]    resp_o,
    output fta_cmd_request128_t                  fta_req,
    input  fta_cmd_response128_t                 fta_resp
);
    localparam int PW = $clog2(NPORTS);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] OUT_LIMIT = CW'(MAX_OUT);
    localparam logic [PW-1:0] LAST_PORT = PW'(NPORTS - 1);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       outst_q [NPORTS];
    logic [CW-1:0]       outst_d [NPORTS];
    fta_cmd_request128_t fta_req_q, fta_req_d;

    logic [NPORTS-1:0]   elig, chan_hit, gnt, inc, dec;
    logic [PW-1:0]       gnt_idx, scan_idx;
    logic                gnt_any;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        assign chan_hit[gi] = (int'(fta_resp.tid.channel) == CHAN_BASE + gi);
        // Writes never count against the read limit, so a full counter only blocks reads.
        assign elig[gi]     = req_i[gi].cyc && !fta_resp.rty &&
                              (req_i[gi].we || (outst_q[gi] < OUT_LIMIT));
        assign inc[gi]      = gnt[gi] && !req_i[gi].we;
        assign dec[gi]      = fta_resp.ack && chan_hit[gi];
    end

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = ptr_q;
        for (int k = 0; k < NPORTS; k++) begin
            if (!gnt_any && elig[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
            scan_idx = (scan_idx == LAST_PORT) ? '0 : scan_idx + 1'b1;
        end
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            resp_o[i]     = '0;
            resp_o[i].tid = req_i[i].tid;
            if (chan_hit[i]) begin
                resp_o[i] = fta_resp;
            end
            resp_o[i].rty = !gnt[i];
        end
    end

    always_comb begin
        fta_req_d = fta_req_q;
        ptr_d     = ptr_q;
        if (!fta_resp.rty) begin
            if (gnt_any) begin
                fta_req_d = req_i[gnt_idx];
            end else begin
                fta_req_d = '0;
            end
        end
        if (gnt_any) begin
            ptr_d = (gnt_idx == LAST_PORT) ? '0 : gnt_idx + 1'b1;
        end
        for (int i = 0; i < NPORTS; i++) begin
            outst_d[i] = outst_q[i];
            if (inc[i] && !dec[i]) begin
                outst_d[i] = outst_q[i] + 1'b1;
            end else if (dec[i] && !inc[i] && (outst_q[i] != '0)) begin
                outst_d[i] = outst_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            fta_req_q <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            fta_req_q <= fta_req_d;
            for (int i = 0; i < NPORTS; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    assign fta_req = fta_req_q;

endmodule

// File: tb/tb_fta_rr_arbiter.sv
// Scoreboard bench for fta_rr_arbiter: a rule-level reference model predicts every
// per-cycle response vector and bus command; a monitor compares them on the falling edge.

module tb_fta_rr_arbiter;
    import fta_arb_pkg::*;

    localparam int N  = 4;
    localparam int CB = 0;
    localparam int MO = 3;

    logic                         clk = 1'b0;
    logic                         rst_n;
    fta_cmd_request128_t  [N-1:0] req_i;
    fta_cmd_response128_t [N-1:0] resp_o;
    fta_cmd_request128_t          fta_req;
    fta_cmd_response128_t         fta_resp;

    always #5 clk = ~clk;

    fta_rr_arbiter #(.NPORTS(N), .CHAN_BASE(CB), .MAX_OUT(MO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .resp_o   (resp_o),
        .fta_req  (fta_req),
        .fta_resp (fta_resp)
    );

    typedef struct {
        int                           cyc;
        fta_cmd_response128_t [N-1:0] r;
    } resp_exp_t;

    typedef struct {
        int                  cyc;
        fta_cmd_request128_t c;
    } cmd_exp_t;

    resp_exp_t resp_q[$];
    cmd_exp_t  cmd_q[$];
    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    // Reference model state: rotating start index, read counts and the bus register.
    int                  m_ptr;
    int                  m_outst[N];
    fta_cmd_request128_t m_req;
    fta_cmd_request128_t pend[N];

    function automatic fta_cmd_request128_t mk(int port, bit we, logic [31:0] adr);
        fta_cmd_request128_t c;
        c             = '0;
        c.cyc         = 1'b1;
        c.we          = we;
        c.sel         = 16'hFFFF;
        c.tid.core    = 4'h1;
        c.tid.channel = 4'(CB + port);
        c.tid.tranid  = 8'($urandom);
        c.padr        = adr;
        c.data1       = {$urandom, $urandom, $urandom, $urandom};
        return c;
    endfunction

    function automatic fta_cmd_response128_t ack_on(int ch, logic [127:0] d);
        fta_cmd_response128_t r;
        r             = '0;
        r.ack         = 1'b1;
        r.tid.channel = 4'(ch);
        r.tid.tranid  = 8'($urandom);
        r.adr         = $urandom;
        r.dat         = d;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Applies the spec rules to the inputs of the current cycle and queues expectations.
    task automatic eval(output int g);
        int                   idx;
        int                   ch;
        bit                   inc, dec;
        fta_cmd_response128_t e;
        resp_exp_t            re;
        cmd_exp_t             ce;
        g  = -1;
        ch = int'(fta_resp.tid.channel);
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && req_i[idx].cyc && !fta_resp.rty &&
                (req_i[idx].we || m_outst[idx] < MO)) begin
                g = idx;
            end
        end
        re.cyc = cycle;
        for (int i = 0; i < N; i++) begin
            e     = '0;
            e.tid = req_i[i].tid;
            if (ch == CB + i) e = fta_resp;
            e.rty   = (g != i);
            re.r[i] = e;
        end
        resp_q.push_back(re);
        if (!rst_n) begin
            m_ptr = 0;
            m_req = '0;
            for (int i = 0; i < N; i++) m_outst[i] = 0;
        end else begin
            if (!fta_resp.rty) begin
                if (g >= 0) m_req = req_i[g];
                else        m_req = '0;
            end
            if (g >= 0) m_ptr = (g + 1) % N;
            for (int i = 0; i < N; i++) begin
                inc = (g == i) && !req_i[i].we;
                dec = fta_resp.ack && (ch == CB + i);
                if (inc && !dec) m_outst[i]++;
                else if (dec && !inc && m_outst[i] > 0) m_outst[i]--;
            end
        end
        ce.cyc = cycle + 1;
        ce.c   = m_req;
        cmd_q.push_back(ce);
        cycle++;
    endtask

    // Masters hold a pending command until accepted, then may issue another.
    task automatic run_masters(int ncyc, logic [N-1:0] act, int we_pct, int ack_pct,
                               int rty_pct, int rst_pct);
        int g;
        for (int c = 0; c < ncyc; c++) begin
            next_cycle();
            rst_n = ($urandom_range(99) >= rst_pct);
            for (int i = 0; i < N; i++) begin
                if (act[i] && !pend[i].cyc && $urandom_range(99) < 80)
                    pend[i] = mk(i, $urandom_range(99) < we_pct, $urandom);
                req_i[i] = act[i] ? pend[i] : '0;
            end
            fta_resp             = '0;
            fta_resp.tid.channel = 4'($urandom_range(7));
            fta_resp.tid.tranid  = 8'($urandom);
            fta_resp.ack         = ($urandom_range(99) < ack_pct);
            fta_resp.rty         = ($urandom_range(99) < rty_pct);
            fta_resp.err         = 1'($urandom);
            fta_resp.adr         = $urandom;
            fta_resp.dat         = {$urandom, $urandom, $urandom, $urandom};
            eval(g);
            if (g >= 0) pend[g].cyc = 1'b0;
        end
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend[i] = '0;
    endtask

    // Monitor: pops whatever expectations belong to the current cycle.
    initial begin
        int        mcyc;
        resp_exp_t re;
        cmd_exp_t  ce;
        mcyc = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            while (resp_q.size() > 0 && resp_q[0].cyc == mcyc) begin
                re = resp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (resp_o[i] === re.r[i]) passes++;
                    else $display("FAIL resp_o[%0d] cycle %0d: got %h required %h",
                                  i, mcyc, resp_o[i], re.r[i]);
                end
            end
            while (cmd_q.size() > 0 && cmd_q[0].cyc == mcyc) begin
                ce = cmd_q.pop_front();
                checks++;
                if (fta_req === ce.c) passes++;
                else $display("FAIL fta_req cycle %0d: got %h required %h",
                              mcyc, fta_req, ce.c);
                if (fta_req.cyc === 1'b1)
                    $display("cmd cycle %0d ch %0d we %0b padr %h", mcyc,
                             fta_req.tid.channel, fta_req.we, fta_req.padr);
            end
            mcyc++;
        end
    end

    initial begin
        int       g;
        cmd_exp_t ce0;
        m_ptr    = 0;
        m_req    = '0;
        for (int i = 0; i < N; i++) m_outst[i] = 0;
        clear_pend();
        rst_n    = 1'b0;
        req_i    = '0;
        fta_resp = '0;
        ce0.cyc  = 0;
        ce0.c    = '0;
        cmd_q.push_back(ce0);

        // Reset, then a single read on port 1 that is acked two cycles later.
        repeat (2) begin next_cycle(); eval(g); end
        rst_n = 1'b1;
        next_cycle(); req_i[1] = mk(1, 1'b0, 32'h1000); eval(g);
        next_cycle(); req_i[1] = '0; eval(g);
        next_cycle(); fta_resp = ack_on(CB + 1, 128'h1); eval(g);
        next_cycle(); fta_resp = '0; eval(g);

        // Continuous writes from ports 0, 2, 3.
        clear_pend();
        run_masters(6, 4'b1101, 100, 0, 0, 0);
        clear_pend();
        next_cycle(); req_i = '0; eval(g);

        // Downstream stall for 3 cycles while port 0 waits.
        run_masters(3, 4'b0001, 100, 0, 100, 0);
        run_masters(2, 4'b0001, 100, 0, 0, 0);
        clear_pend();

        // Port 1 reads until the counter is full; an ack releases the next one.
        run_masters(8, 4'b0010, 0, 0, 0, 0);
        next_cycle(); req_i = '0; req_i[1] = pend[1]; fta_resp = ack_on(CB + 1, 128'h2); eval(g);
        if (g >= 0) pend[1].cyc = 1'b0;
        clear_pend();

        // Ack to port 2 coinciding with a read grant to port 2, then an unmapped channel.
        next_cycle(); req_i = '0; req_i[2] = mk(2, 1'b0, 32'h2000);
        fta_resp = ack_on(CB + 2, 128'hDEAD); eval(g);
        next_cycle(); req_i = '0; fta_resp = ack_on(7, 128'hBEEF); eval(g);
        next_cycle(); fta_resp = '0; eval(g);

        // Fill port 0, reset for one cycle, then a late ack and fresh reads.
        run_masters(6, 4'b0001, 0, 0, 0, 0);
        clear_pend();
        next_cycle(); rst_n = 1'b0; req_i = '0; fta_resp = '0; eval(g);
        next_cycle(); rst_n = 1'b1; fta_resp = ack_on(CB + 0, 128'h3); eval(g);
        run_masters(6, 4'b0001, 0, 0, 0, 0);
        clear_pend();

        // Random traffic with acks, stalls, unmapped channels and occasional resets.
        run_masters(3000, 4'b1111, 50, 30, 10, 1);

        next_cycle(); req_i = '0; fta_resp = '0; rst_n = 1'b1; eval(g);
        repeat (3) @(negedge clk);
        checks++;
        if (resp_q.size() == 0 && cmd_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d/%0d entries left required 0/0",
                      resp_q.size(), cmd_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
